// File: rtl/pp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pp_pkg                                                         |
// | Brief    : Shared types and column-geometry helpers for the PP datapath.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package pp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pp_state_e;

    // Number of partial-product bits in weight column k of an n x n array.
    function automatic int col_height_f(input int k, input int n);
        return (k < n) ? k + 1 : 2 * n - 1 - k;
    endfunction

    // Lowest row index that contributes to weight column k.
    function automatic int col_first_row_f(input int k, input int n);
        return (k > n - 1) ? k - n + 1 : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pp_col_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pp_col_select                                                  |
// | Brief    : Combinational extraction of one packed partial-product column. |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module pp_col_select
    import pp_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int TRUNC = 0,
    localparam int KW    = $clog2(2 * N - 1),
    localparam int HW    = $clog2(N + 1)
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  bits,
    output logic [HW-1:0] height
);

    localparam int IW = $clog2(N);

    always_comb begin
        int kk;
        int i0;
        int h;
        kk     = int'(k);
        i0     = col_first_row_f(kk, N);
        h      = col_height_f(kk, N);
        bits   = '0;
        height = '0;
        // Truncated columns still exist as beats but carry no bits.
        if (kk >= TRUNC && kk <= 2 * N - 2) begin
            height = HW'(h);
            for (int p = 0; p < N; p++) begin
                if (p < h) begin
                    bits[p] = a[IW'(kk - i0 - p)] & b[IW'(i0 + p)];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pp_column_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pp_column_feeder                                               |
// | Brief    : Streams the AND partial-product array one column per beat.     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module pp_column_feeder
    import pp_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int TRUNC = 0,
    localparam int KW    = $clog2(2 * N - 1),
    localparam int HW    = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  col_bits,
    output logic [HW-1:0] col_height,
    output logic [KW-1:0] col_idx,
    output logic          col_last
);

    localparam logic [KW-1:0] c_last_col = KW'(2 * N - 2);

    pp_state_e     r_state;
    pp_state_e     w_state_nxt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [KW-1:0] r_col;
    logic [KW-1:0] w_col_nxt;
    logic          w_accept;
    logic [N-1:0]  w_bits;
    logic [HW-1:0] w_height;

    pp_col_select #(
        .N     (N),
        .TRUNC (TRUNC)
    ) u_col_select (
        .a      (r_a),
        .b      (r_b),
        .k      (r_col),
        .bits   (w_bits),
        .height (w_height)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_col_nxt   = '0;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_col == c_last_col) begin
                        w_col_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
            end
        end
    end

    // Column payload is blanked outside EMIT so idle outputs read as zero.
    assign col_bits   = out_valid ? w_bits : '0;
    assign col_height = out_valid ? w_height : '0;
    assign col_idx    = r_col;
    assign col_last   = out_valid && (r_col == c_last_col);

endmodule
`default_nettype wire
